// File: rtl/mul_issue_ctrl_if.sv
// Bus bundle between the execute pipeline, the 32x32 multiplier and the
// downstream stage, as seen by the multiply issue/collect controller.
//   in_*   : op request channel (valid/ready) from the execute pipeline
//   mul_*  : launch/return channel to the multiplier
//   out_*  : result channel (valid/ready) to the downstream stage
// Modports:
//   slave  : the controller
//   master : everything around it (pipeline, multiplier, downstream)
interface mul_issue_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;

    logic             mul_start;
    logic             mul_signed_op;
    logic [31:0]      mul_reg1;
    logic [31:0]      mul_reg2;
    logic             mul_done;
    logic [63:0]      mul_result;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag,
        input  mul_done, mul_result, out_ready,
        output in_ready, mul_start, mul_signed_op, mul_reg1, mul_reg2,
        output out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag,
        output mul_done, mul_result, out_ready,
        input  in_ready, mul_start, mul_signed_op, mul_reg1, mul_reg2,
        input  out_valid, out_data, out_tag
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// EX-stage issue/collect controller for the 32x32 multiplier.
// Accepts one MUL.W / MULH.W / MULH.WU op, launches the multiplier, waits for
// its done pulse (with a watchdog), selects the low/high product word and
// holds it until the downstream stage takes it.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush     : kills any in-flight op, returns to IDLE
//   bus       : op request, multiplier and result channels (slave modport)
//   busy      : controller not idle (stall request)
//   err       : one-cycle pulse on watchdog abort
//   op_count  : results delivered downstream (wraps)
module mul_issue_ctrl #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    mul_issue_ctrl_if.slave  bus,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ready_c;
    logic             accept_c;
    logic             expire_c;
    logic             handoff_c;

    logic             hi_q;
    logic [TAG_W-1:0] tag_q;
    logic [WD_W-1:0]  wd_cnt;
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic [TAG_W-1:0] out_tag_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, accept handshake, watchdog expiry and result handoff
    always_comb begin
        state_nxt = state;
        expire_c  = 1'b0;
        handoff_c = 1'b0;
        ready_c   = (state == IDLE) && !flush && !rst;
        accept_c  = bus.in_valid && ready_c;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // done wins over an expiry landing in the same cycle
                if (bus.mul_done) begin
                    state_nxt = HOLD;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    expire_c  = 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                    handoff_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Op context, watchdog counter, result registers and status
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q        <= 1'b0;
            tag_q       <= '0;
            wd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            op_count    <= '0;
        end else begin
            err  <= 1'b0;
            busy <= (state_nxt != IDLE);
            if (accept_c) begin
                // high word only for 01/10; reserved 11 behaves as MUL.W
                hi_q  <= bus.in_op[0] ^ bus.in_op[1];
                tag_q <= bus.in_tag;
            end
            // zero outside WAIT so every WAIT entry starts counting from 0
            if (state == WAIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (flush) begin
                out_valid_q <= 1'b0;
            end else begin
                if (state == WAIT && bus.mul_done) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= hi_q ? bus.mul_result[63:32] : bus.mul_result[31:0];
                    out_tag_q   <= tag_q;
                end
                if (expire_c) begin
                    err <= 1'b1;
                end
                if (handoff_c) begin
                    out_valid_q <= 1'b0;
                    op_count    <= op_count + CNT_W'(1);
                end
            end
        end
    end

    // Launch is combinational in the accept cycle; operands pass straight through
    assign bus.in_ready      = ready_c;
    assign bus.mul_start     = accept_c;
    assign bus.mul_signed_op = (bus.in_op == 2'b01);
    assign bus.mul_reg1      = bus.in_src1;
    assign bus.mul_reg2      = bus.in_src2;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_tag       = out_tag_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed scenarios followed by
// randomized ops, checked against a word-level reference of the multiply ops
// and a simple latency-programmable multiplier model.
module tb_mul_issue_ctrl;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 32;

    typedef struct {
        int          due;
        logic [63:0] prod;
    } pend_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] op_count;

    mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mul_issue_ctrl #(
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .busy     (busy),
        .err      (err),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int    tests   = 0;
    int    fails   = 0;
    int    cyc     = 0;
    int    lat     = 1;
    bit    mul_en  = 1'b1;
    int    acc_cyc = 0;
    int    exp_cnt = 0;
    pend_t pend[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of each op, computed from full-width products
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] u;
        logic [63:0] s;
        u = {32'd0, a} * {32'd0, b};
        s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        case (op)
            2'd1:    return s[63:32];
            2'd2:    return u[63:32];
            default: return u[31:0];
        endcase
    endfunction

    // One clock: multiplier model captures starts mid-cycle, answers lat cycles later
    task automatic tick();
        logic [63:0] a;
        logic [63:0] b;
        @(negedge clk);
        if (bus.mul_start && mul_en) begin
            if (bus.mul_signed_op) begin
                a = {{32{bus.mul_reg1[31]}}, bus.mul_reg1};
                b = {{32{bus.mul_reg2[31]}}, bus.mul_reg2};
            end else begin
                a = {32'd0, bus.mul_reg1};
                b = {32'd0, bus.mul_reg2};
            end
            pend.push_back('{cyc + lat, a * b});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            bus.mul_done   = 1'b1;
            bus.mul_result = pend[0].prod;
            void'(pend.pop_front());
        end else begin
            bus.mul_done   = 1'b0;
            bus.mul_result = {$urandom, $urandom};
        end
        #1;
    endtask

    // Present an op in an IDLE cycle, check the launch, advance one cycle
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_tag   = tag;
        #1;
        chk("acc_in_ready", 64'(bus.in_ready), 64'(1));
        chk("acc_mul_start", 64'(bus.mul_start), 64'(1));
        chk("acc_signed_op", 64'(bus.mul_signed_op), 64'(op == 2'd1));
        chk("acc_reg1", 64'(bus.mul_reg1), 64'(a));
        chk("acc_reg2", 64'(bus.mul_reg2), 64'(b));
        acc_cyc = cyc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Full op: accept, done, hold for 'hold' stalled cycles, handoff
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int hold);
        logic [31:0] exp_d;
        exp_d = ref_res(op, a, b);
        bus.out_ready = 1'b0;
        issue(op, a, b, tag);
        chk("wait_busy", 64'(busy), 64'(1));
        chk("wait_out_valid", 64'(bus.out_valid), 64'(0));
        chk("wait_in_ready", 64'(bus.in_ready), 64'(0));
        chk("wait_mul_start", 64'(bus.mul_start), 64'(0));
        tick();
        chk("res_valid", 64'(bus.out_valid), 64'(1));
        chk("res_data", 64'(bus.out_data), 64'(exp_d));
        chk("res_tag", 64'(bus.out_tag), 64'(tag));
        chk("res_in_ready", 64'(bus.in_ready), 64'(0));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            tick();
            chk("hold_valid", 64'(bus.out_valid), 64'(1));
            chk("hold_data", 64'(bus.out_data), 64'(exp_d));
            chk("hold_tag", 64'(bus.out_tag), 64'(tag));
            chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
            chk("hold_mul_start", 64'(bus.mul_start), 64'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("take_valid", 64'(bus.out_valid), 64'(0));
        chk("take_count", 64'(op_count), 64'(exp_cnt));
        chk("take_busy", 64'(busy), 64'(0));
        chk("take_in_ready", 64'(bus.in_ready), 64'(1));
        chk("take_err", 64'(err), 64'(0));
    endtask

    initial begin
        int          prev;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst            = 1'b1;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_op      = 2'd0;
        bus.in_src1    = '0;
        bus.in_src2    = '0;
        bus.in_tag     = '0;
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
        bus.out_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_count", 64'(op_count), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

        // The three ops plus the reserved encoding on the same operands
        run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 0);

        // Backpressure: three stalled HOLD cycles, taken on the fourth
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 3);

        // Back-to-back: initiation interval of 3 cycles
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), $urandom, $urandom, 5'(10 + i), 0);
            if (i > 0) chk("b2b_interval", 64'(acc_cyc - prev), 64'(3));
            prev = acc_cyc;
        end

        // Flush in WAIT; the late done lands in IDLE on top of a new accept
        lat = 2;
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
        tick();
        flush = 1'b0;
        lat   = 1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_err", 64'(err), 64'(0));
        chk("flush_count", 64'(op_count), 64'(exp_cnt));
        run_op(2'd2, 32'hDEAD_BEEF, 32'h0000_0010, 5'd3, 0);

        // Flush and out_ready together in HOLD: result dropped
        issue(2'd0, 32'h0000_0003, 32'h0000_0005, 5'd21);
        tick();
        chk("fhold_valid", 64'(bus.out_valid), 64'(1));
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        chk("fhold_out_valid", 64'(bus.out_valid), 64'(0));
        chk("fhold_count", 64'(op_count), 64'(exp_cnt));
        chk("fhold_err", 64'(err), 64'(0));
        chk("fhold_busy", 64'(busy), 64'(0));

        // Watchdog: multiplier never answers
        mul_en = 1'b0;
        issue(2'd1, 32'h0000_0007, 32'h0000_0009, 5'd30);
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            chk("wd_err_low", 64'(err), 64'(0));
            chk("wd_busy", 64'(busy), 64'(1));
            tick();
        end
        chk("wd_err_pulse", 64'(err), 64'(1));
        chk("wd_out_valid", 64'(bus.out_valid), 64'(0));
        chk("wd_in_ready", 64'(bus.in_ready), 64'(1));
        chk("wd_busy_low", 64'(busy), 64'(0));
        chk("wd_count", 64'(op_count), 64'(exp_cnt));
        tick();
        chk("wd_err_once", 64'(err), 64'(0));
        mul_en = 1'b1;

        // Reset in WAIT; late done arrives while held in reset
        lat = 2;
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);
        rst = 1'b1;
        tick();
        chk("rstw_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rstw_out_data", 64'(bus.out_data), 64'(0));
        chk("rstw_out_tag", 64'(bus.out_tag), 64'(0));
        chk("rstw_busy", 64'(busy), 64'(0));
        chk("rstw_err", 64'(err), 64'(0));
        chk("rstw_count", 64'(op_count), 64'(0));
        chk("rstw_in_ready", 64'(bus.in_ready), 64'(0));
        rst     = 1'b0;
        lat     = 1;
        exp_cnt = 0;
        tick();
        run_op(2'd0, 32'h0000_0006, 32'h0000_0007, 5'd5, 1);

        // Randomized ops with corner operands mixed in
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            rb  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op(rop, ra, rb, 5'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
